// File: rtl/dps_irq_ctrl_n.sv
// N-channel priority interrupt controller with a per-channel mask/valid/level table.
// Define DPS_IRQ_ROUND_ROBIN_EN to rotate equal-level ties with a round-robin pointer.
module dps_irq_ctrl_n #(
    parameter int unsigned P_CH    = 8,
    parameter int unsigned P_CH_W  = 3,
    parameter int unsigned P_LVL_W = 2
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic               iCFG_REQ,
    input  logic [P_CH_W-1:0]  iCFG_ENTRY,
    input  logic               iCFG_MASK,
    input  logic               iCFG_VALID,
    input  logic [P_LVL_W-1:0] iCFG_LEVEL,
    input  logic [P_CH-1:0]    iIRQ_REQ,
    output logic [P_CH-1:0]    oIRQ_SRC_ACK,
    output logic               oIRQ_VALID,
    output logic [P_CH_W-1:0]  oIRQ_NUM,
    output logic [P_LVL_W-1:0] oIRQ_LEVEL,
    input  logic               iIRQ_ACK
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        ACK_WAIT = 1'b1
    } tState;

    tState              state;
    tState              stateNext;

    logic [P_CH-1:0]    cfgValid;
    logic [P_CH-1:0]    cfgMask;
    logic [P_LVL_W-1:0] cfgLevel [P_CH];

    logic [P_CH-1:0]    eligible;
    logic [P_LVL_W-1:0] effLevel [P_CH];

    logic               selValid;
    logic [P_CH_W-1:0]  selNum;
    logic [P_LVL_W-1:0] selLevel;
    logic               grant;

    // Configuration table; entries beyond P_CH never match and are dropped.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            cfgValid <= '0;
            cfgMask  <= '0;
            for (int i = 0; i < P_CH; i++) begin
                cfgLevel[i] <= '0;
            end
        end else if (iCFG_REQ) begin
            for (int i = 0; i < P_CH; i++) begin
                if (iCFG_ENTRY == P_CH_W'(i)) begin
                    cfgValid[i] <= iCFG_VALID;
                    cfgMask[i]  <= iCFG_MASK;
                    cfgLevel[i] <= iCFG_LEVEL;
                end
            end
        end
    end

    // Unconfigured channels pass through at level 0.
    always_comb begin
        for (int i = 0; i < P_CH; i++) begin
            eligible[i] = iIRQ_REQ[i] && (!cfgValid[i] || cfgMask[i]);
            effLevel[i] = cfgValid[i] ? cfgLevel[i] : '0;
        end
    end

`ifdef DPS_IRQ_ROUND_ROBIN_EN
    localparam int unsigned LP_IDX_W = P_CH_W + 1;

    logic [P_CH_W-1:0]   rrPtr;
    logic [LP_IDX_W-1:0] scanIdx;

    // Scan in rotated order from rrPtr; strict '>' keeps the first hit at the top level.
    always_comb begin
        selValid = 1'b0;
        selNum   = '0;
        selLevel = '0;
        scanIdx  = '0;
        for (int k = 0; k < P_CH; k++) begin
            scanIdx = {1'b0, rrPtr} + LP_IDX_W'(k);
            if (scanIdx >= LP_IDX_W'(P_CH)) begin
                scanIdx = scanIdx - LP_IDX_W'(P_CH);
            end
            for (int i = 0; i < P_CH; i++) begin
                if ((scanIdx == LP_IDX_W'(i)) && eligible[i] &&
                    (!selValid || (effLevel[i] > selLevel))) begin
                    selValid = 1'b1;
                    selNum   = P_CH_W'(i);
                    selLevel = effLevel[i];
                end
            end
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rrPtr <= '0;
        end else if (grant) begin
            rrPtr <= (selNum == P_CH_W'(P_CH - 1)) ? '0 : selNum + 1'b1;
        end
    end
`else
    // Ascending scan with strict '>' so equal levels resolve to the lowest index.
    always_comb begin
        selValid = 1'b0;
        selNum   = '0;
        selLevel = '0;
        for (int i = 0; i < P_CH; i++) begin
            if (eligible[i] && (!selValid || (effLevel[i] > selLevel))) begin
                selValid = 1'b1;
                selNum   = P_CH_W'(i);
                selLevel = effLevel[i];
            end
        end
    end
`endif

    assign grant = (state == IDLE) && selValid;

    // Pending vector is frozen from grant until the next grant.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            oIRQ_NUM   <= '0;
            oIRQ_LEVEL <= '0;
        end else if (grant) begin
            oIRQ_NUM   <= selNum;
            oIRQ_LEVEL <= selLevel;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:     if (selValid) stateNext = ACK_WAIT;
            ACK_WAIT: if (iIRQ_ACK) stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    // Source acknowledge is a same-cycle pulse in IDLE only.
    always_comb begin
        oIRQ_VALID   = (state == ACK_WAIT);
        oIRQ_SRC_ACK = '0;
        for (int i = 0; i < P_CH; i++) begin
            oIRQ_SRC_ACK[i] = grant && (selNum == P_CH_W'(i));
        end
    end

endmodule

// File: tb/tb_dps_irq_ctrl_n.sv
// Bench for dps_irq_ctrl_n: per-cycle comparison against a table/priority model plus directed literal checks.
module tb_dps_irq_ctrl_n;

    localparam int P_CH    = 8;
    localparam int P_CH_W  = 3;
    localparam int P_LVL_W = 2;

    logic               iCLOCK = 1'b0;
    logic               inRESET = 1'b0;
    logic               iCFG_REQ = 1'b0;
    logic [P_CH_W-1:0]  iCFG_ENTRY = '0;
    logic               iCFG_MASK = 1'b0;
    logic               iCFG_VALID = 1'b0;
    logic [P_LVL_W-1:0] iCFG_LEVEL = '0;
    logic [P_CH-1:0]    iIRQ_REQ = '0;
    logic [P_CH-1:0]    oIRQ_SRC_ACK;
    logic               oIRQ_VALID;
    logic [P_CH_W-1:0]  oIRQ_NUM;
    logic [P_LVL_W-1:0] oIRQ_LEVEL;
    logic               iIRQ_ACK = 1'b0;

    dps_irq_ctrl_n #(.P_CH(P_CH), .P_CH_W(P_CH_W), .P_LVL_W(P_LVL_W)) dut (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iCFG_REQ    (iCFG_REQ),
        .iCFG_ENTRY  (iCFG_ENTRY),
        .iCFG_MASK   (iCFG_MASK),
        .iCFG_VALID  (iCFG_VALID),
        .iCFG_LEVEL  (iCFG_LEVEL),
        .iIRQ_REQ    (iIRQ_REQ),
        .oIRQ_SRC_ACK(oIRQ_SRC_ACK),
        .oIRQ_VALID  (oIRQ_VALID),
        .oIRQ_NUM    (oIRQ_NUM),
        .oIRQ_LEVEL  (oIRQ_LEVEL),
        .iIRQ_ACK    (iIRQ_ACK)
    );

    always #5 iCLOCK = ~iCLOCK;

    int nChecks = 0;
    int nPass   = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Model: table contents, pending flag, latched vector and rotation pointer.
    bit mValid [P_CH];
    bit mMask  [P_CH];
    int mLvl   [P_CH];
    bit mBusy;
    int mNum;
    int mLevel;
    int mRr;

    function automatic int effLvl(input int i);
        return mValid[i] ? mLvl[i] : 0;
    endfunction

    function automatic bit elig(input int i);
        return iIRQ_REQ[i] && (!mValid[i] || mMask[i]);
    endfunction

    // Winner: find the top eligible level, then the first channel at that level in scan order.
    function automatic int modelSel();
        int best = -1;
        int c;
        for (int i = 0; i < P_CH; i++)
            if (elig(i) && effLvl(i) > best) best = effLvl(i);
        if (best < 0) return -1;
        for (int k = 0; k < P_CH; k++) begin
`ifdef DPS_IRQ_ROUND_ROBIN_EN
            c = (mRr + k) % P_CH;
`else
            c = k;
`endif
            if (elig(c) && effLvl(c) == best) return c;
        end
        return -1;
    endfunction

    function automatic logic [P_CH-1:0] expAck();
        int s = modelSel();
        if (mBusy || s < 0) return '0;
        return P_CH'(1) << s;
    endfunction

    always @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            for (int i = 0; i < P_CH; i++) begin
                mValid[i] <= 1'b0;
                mMask[i]  <= 1'b0;
                mLvl[i]   <= 0;
            end
            mBusy  <= 1'b0;
            mNum   <= 0;
            mLevel <= 0;
            mRr    <= 0;
        end else begin
            if (!mBusy && modelSel() >= 0) begin
                mBusy  <= 1'b1;
                mNum   <= modelSel();
                mLevel <= effLvl(modelSel());
                mRr    <= (modelSel() + 1) % P_CH;
            end else if (mBusy && iIRQ_ACK) begin
                mBusy <= 1'b0;
            end
            if (iCFG_REQ && int'(iCFG_ENTRY) < P_CH) begin
                mValid[int'(iCFG_ENTRY)] <= iCFG_VALID;
                mMask[int'(iCFG_ENTRY)]  <= iCFG_MASK;
                mLvl[int'(iCFG_ENTRY)]   <= int'(iCFG_LEVEL);
            end
        end
    end

    initial begin
        forever begin
            @(negedge iCLOCK);
            if (started) begin
                chk("m_src_ack", oIRQ_SRC_ACK, expAck());
                chk("m_onehot", ($countones(oIRQ_SRC_ACK) <= 1), 1);
                chk("m_valid", oIRQ_VALID, mBusy);
                chk("m_num", oIRQ_NUM, mNum);
                chk("m_level", oIRQ_LEVEL, mLevel);
            end
        end
    end

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic cfgWrite(input int e, input bit m, input bit v, input int l);
        iCFG_ENTRY = P_CH_W'(e);
        iCFG_MASK  = m;
        iCFG_VALID = v;
        iCFG_LEVEL = P_LVL_W'(l);
        iCFG_REQ   = 1'b1;
        tick();
        iCFG_REQ   = 1'b0;
    endtask

    task automatic coreAck();
        iIRQ_ACK = 1'b1;
        tick();
        iIRQ_ACK = 1'b0;
    endtask

    int exp4 [3];

    initial begin
`ifdef DPS_IRQ_ROUND_ROBIN_EN
        exp4 = '{0, 4, 6};
`else
        exp4 = '{0, 0, 0};
`endif
        repeat (2) tick();
        chk("rst_valid", oIRQ_VALID, 0);
        chk("rst_num", oIRQ_NUM, 0);
        chk("rst_level", oIRQ_LEVEL, 0);
        chk("rst_src_ack", oIRQ_SRC_ACK, 0);
        started  = 1'b1;
        inRESET  = 1'b1;

        // Unconfigured channel passes at level 0.
        iIRQ_REQ = 8'h04;
        #1;
        chk("t1_src_ack", oIRQ_SRC_ACK, 8'h04);
        tick();
        iIRQ_REQ = 8'h00;
        chk("t1_valid", oIRQ_VALID, 1);
        chk("t1_num", oIRQ_NUM, 2);
        chk("t1_level", oIRQ_LEVEL, 0);
        coreAck();
        chk("t1_valid_clr", oIRQ_VALID, 0);

        // Core ack in IDLE does nothing; masked channel is held off.
        coreAck();
        chk("idle_ack_ignored", oIRQ_VALID, 0);
        cfgWrite(1, 1'b0, 1'b1, 0);
        iIRQ_REQ = 8'h02;
        repeat (10) tick();
        chk("t2_masked_valid", oIRQ_VALID, 0);
        chk("t2_masked_ack", oIRQ_SRC_ACK, 0);
        cfgWrite(1, 1'b1, 1'b1, 0);
        chk("t2_unmasked_ack", oIRQ_SRC_ACK, 8'h02);
        tick();
        iIRQ_REQ = 8'h00;
        chk("t2_num", oIRQ_NUM, 1);
        coreAck();

        // Priority ordering.
        cfgWrite(3, 1'b1, 1'b1, 3);
        cfgWrite(5, 1'b1, 1'b1, 1);
        iIRQ_REQ = 8'h28;
        tick();
        chk("t3_num_hi", oIRQ_NUM, 3);
        chk("t3_level_hi", oIRQ_LEVEL, 3);
        iIRQ_REQ = 8'h20;
        coreAck();
        chk("t3_src_ack", oIRQ_SRC_ACK, 8'h20);
        tick();
        iIRQ_REQ = 8'h00;
        chk("t3_num_lo", oIRQ_NUM, 5);
        chk("t3_level_lo", oIRQ_LEVEL, 1);
        coreAck();

        // Equal-level tie resolution from a fresh reset.
        inRESET = 1'b0;
        tick();
        inRESET = 1'b1;
        cfgWrite(0, 1'b1, 1'b1, 2);
        cfgWrite(4, 1'b1, 1'b1, 2);
        cfgWrite(6, 1'b1, 1'b1, 2);
        iIRQ_REQ = 8'h51;
        for (int g = 0; g < 3; g++) begin
            tick();
            chk($sformatf("t4_grant%0d", g), oIRQ_NUM, exp4[g]);
            coreAck();
        end
        iIRQ_REQ = 8'h00;

        // Config write on the in-flight channel leaves the pending vector alone.
        iIRQ_REQ = 8'h04;
        tick();
        chk("t5_num", oIRQ_NUM, 2);
        iIRQ_REQ = 8'h84;
        cfgWrite(2, 1'b0, 1'b1, 3);
        chk("t5_num_hold", oIRQ_NUM, 2);
        chk("t5_level_hold", oIRQ_LEVEL, 0);
        chk("t5_src_ack_hold", oIRQ_SRC_ACK, 0);
        iIRQ_REQ = 8'h80;
        repeat (2) tick();
        chk("t5_num_hold2", oIRQ_NUM, 2);
        coreAck();
        chk("t5_src_ack7", oIRQ_SRC_ACK, 8'h80);
        tick();
        iIRQ_REQ = 8'h00;
        chk("t5_num7", oIRQ_NUM, 7);
        coreAck();

        // Asynchronous reset while pending.
        iIRQ_REQ = 8'h01;
        tick();
        chk("t6_level_pre", oIRQ_LEVEL, 2);
        #1 inRESET = 1'b0;
        #1;
        chk("t6_async_valid", oIRQ_VALID, 0);
        chk("t6_async_num", oIRQ_NUM, 0);
        #1 inRESET = 1'b1;
        tick();
        chk("t6_valid_post", oIRQ_VALID, 1);
        chk("t6_num_post", oIRQ_NUM, 0);
        chk("t6_level_post", oIRQ_LEVEL, 0);
        iIRQ_REQ = 8'h00;
        coreAck();
        repeat (2) tick();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
